// File: rtl/result_writer.sv
// result_writer: gathers 8-bit MAC results and packs four per little-endian word into sequential memory addresses.
// Build option: define WRITER_RELU_EN to clamp negative results to zero before packing.
module result_writer #(
  parameter int macCount = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            baseAdr,
  input  logic [7:0]            outCount,
  input  logic [macCount-1:0]   resValid,
  input  logic [8*macCount-1:0] resData,
  output logic [macCount-1:0]   resReady,
  output logic                  memWe,
  output logic [7:0]            memAdr,
  output logic [31:0]           memData,
  output logic                  busy,
  output logic                  done
);

  localparam int IW = (macCount > 1) ? $clog2(macCount) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_t;

  state_t             state, stateNext;
  logic [7:0]         adrCnt, target, acceptCnt, drainCnt;
  logic [1:0]         lane;
  logic [23:0]        packBuf;
  logic [macCount-1:0] bufFull;
  logic [7:0]         bufData [macCount];
  logic [IW-1:0]      lastGrant, grantIdx, cand;
  logic               grantVld;
  logic [7:0]         drainRaw, drainByte;
  logic [8:0]         acceptSum;
  logic [macCount-1:0] accept;
  logic               lastDrain;

  // Lower indices claim the remaining result budget first.
  always_comb begin
    resReady  = '0;
    accept    = '0;
    acceptSum = {1'b0, acceptCnt};
    for (int i = 0; i < macCount; i++) begin
      if (state == RUN && !bufFull[i] && acceptSum < {1'b0, target}) begin
        resReady[i] = 1'b1;
        if (resValid[i]) begin
          accept[i] = 1'b1;
          acceptSum = acceptSum + 9'd1;
        end
      end
    end
  end

  // Scan from farthest to nearest so the first full buffer after lastGrant wins.
  always_comb begin
    grantVld = 1'b0;
    grantIdx = '0;
    cand     = '0;
    if (state == RUN) begin
      for (int k = macCount; k >= 1; k--) begin
        cand = IW'((int'(lastGrant) + k) % macCount);
        if (bufFull[cand]) begin
          grantVld = 1'b1;
          grantIdx = cand;
        end
      end
    end
  end

  always_comb begin
    drainRaw = bufData[grantIdx];
`ifdef WRITER_RELU_EN
    drainByte = drainRaw[7] ? 8'h00 : drainRaw;
`else
    drainByte = drainRaw;
`endif
  end

  assign lastDrain = grantVld && (drainCnt + 8'd1 == target);
  assign busy      = (state == RUN) || (state == FLUSH);

  // A final drain that completes a word already writes it, so FLUSH is skipped.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = (outCount == 8'd0) ? FIN : RUN;
      RUN:     if (lastDrain) stateNext = (lane == 2'd3) ? FIN : FLUSH;
      FLUSH:   stateNext = FIN;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      adrCnt    <= '0;
      target    <= '0;
      acceptCnt <= '0;
      drainCnt  <= '0;
      lane      <= '0;
      packBuf   <= '0;
      bufFull   <= '0;
      lastGrant <= '0;
      memWe     <= 1'b0;
      memAdr    <= '0;
      memData   <= '0;
      done      <= 1'b0;
      for (int i = 0; i < macCount; i++) bufData[i] <= '0;
    end else begin
      state     <= stateNext;
      memWe     <= 1'b0;
      done      <= (state == FIN);
      acceptCnt <= acceptSum[7:0];

      if (state == IDLE && start) begin
        adrCnt    <= baseAdr;
        target    <= outCount;
        acceptCnt <= '0;
        drainCnt  <= '0;
        lane      <= '0;
        packBuf   <= '0;
        lastGrant <= IW'(macCount - 1);
      end

      for (int i = 0; i < macCount; i++) begin
        if (accept[i]) begin
          bufFull[i] <= 1'b1;
          bufData[i] <= resData[8*i +: 8];
        end
      end

      if (grantVld) begin
        bufFull[grantIdx] <= 1'b0;
        lastGrant         <= grantIdx;
        drainCnt          <= drainCnt + 8'd1;
        lane              <= lane + 2'd1;
        case (lane)
          2'd0: packBuf[7:0]   <= drainByte;
          2'd1: packBuf[15:8]  <= drainByte;
          2'd2: packBuf[23:16] <= drainByte;
          default: begin
            memWe   <= 1'b1;
            memAdr  <= adrCnt;
            memData <= {drainByte, packBuf};
            adrCnt  <= adrCnt + 8'd1;
            packBuf <= '0;
          end
        endcase
      end

      if (state == FLUSH && lane != 2'd0) begin
        memWe   <= 1'b1;
        memAdr  <= adrCnt;
        memData <= {8'h00, packBuf};
        adrCnt  <= adrCnt + 8'd1;
        lane    <= '0;
        packBuf <= '0;
      end
    end
  end

endmodule

// File: tb/tb_result_writer.sv
// Bench for result_writer: directed and random jobs checked against a byte-list packing model with timing expectations.
module tb_result_writer;
  localparam int MC = 4;

  logic            clk = 1'b0;
  logic            rst, start;
  logic [7:0]      baseAdr, outCount;
  logic [MC-1:0]   resValid, resReady;
  logic [8*MC-1:0] resData;
  logic            memWe, busy, done;
  logic [7:0]      memAdr;
  logic [31:0]     memData;

  result_writer #(.macCount(MC)) dut (
    .clk(clk), .rst(rst), .start(start), .baseAdr(baseAdr), .outCount(outCount),
    .resValid(resValid), .resData(resData), .resReady(resReady),
    .memWe(memWe), .memAdr(memAdr), .memData(memData), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  logic [7:0]  wrAdr[$];
  logic [31:0] wrDat[$];
  int          wrCyc[$];
  int          doneCyc[$];
  logic [7:0]  pat[$];
  int          firstK;

  always @(negedge clk) begin
    if (memWe) begin
      wrAdr.push_back(memAdr);
      wrDat.push_back(memData);
      wrCyc.push_back(cyc);
    end
    if (done) doneCyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] relu(input logic [7:0] b);
`ifdef WRITER_RELU_EN
    return b[7] ? 8'h00 : b;
`else
    return b;
`endif
  endfunction

  task automatic chkWord(input string tag, input int w, input logic [7:0] expAdr, input logic [31:0] expDat);
    chk({tag, "_adr"}, (wrAdr.size() > w) ? 32'(wrAdr[w]) : 32'hxxxxxxxx, 32'(expAdr));
    chk({tag, "_dat"}, (wrDat.size() > w) ? wrDat[w] : 32'hxxxxxxxx, expDat);
  endtask

  task automatic clearLogs();
    wrAdr.delete(); wrDat.delete(); wrCyc.delete(); doneCyc.delete();
  endtask

  // Runs one job starting at a negedge; wave mode presents all MACs at once only when every buffer is empty.
  task automatic runJob(input logic [7:0] base, input int cnt, input bit wave, input bit noise);
    logic [7:0]  acc[$];
    logic [7:0]  cb;
    logic [31:0] word;
    int n, got, budget, lastA, lastK, k, nWords, idx, expDone;
    clearLogs();
    firstK = 0;
    start = 1'b1; baseAdr = base; outCount = cnt[7:0]; n = cyc;
    @(negedge clk);
    start = 1'b0; baseAdr = 8'($urandom); outCount = 8'($urandom);
    chk("busy_n1", 32'(busy), (cnt > 0) ? 32'd1 : 32'd0);
    got = 0; budget = 0; lastA = n; lastK = 0;
    while (got < cnt && budget < 2000) begin
      k = 0;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      resValid = '0;
      if (wave) begin
        #1;
        if (resReady == {MC{1'b1}}) begin
          for (int i = 0; i < MC; i++) begin
            cb = (pat.size() > i) ? pat[i] : 8'($urandom);
            resData[8*i +: 8] = cb;
          end
          resValid = {MC{1'b1}};
        end
      end else begin
        resData[7:0] = (pat.size() > 0) ? pat[0] : 8'($urandom);
        resValid[0]  = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int i = 0; i < MC; i++) begin
        if (resValid[i] && resReady[i]) begin
          acc.push_back(resData[8*i +: 8]);
          k++;
        end
      end
      if (k > 0) begin
        if (firstK == 0) firstK = k;
        lastA = cyc; lastK = k; got += k;
        for (int j = 0; j < k; j++) if (pat.size() > 0) void'(pat.pop_front());
      end
      @(negedge clk);
      budget++;
    end
    resValid = '0; start = 1'b0;
    chk("accepted", got, cnt);
    budget = 0;
    while (doneCyc.size() == 0 && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    repeat (3) @(negedge clk);

    nWords = (cnt + 3) / 4;
    chk("nwrites", wrAdr.size(), nWords);
    for (int w = 0; w < nWords; w++) begin
      word = '0;
      for (int b = 0; b < 4; b++) begin
        idx = 4 * w + b;
        if (idx < cnt && idx < acc.size()) word[8*b +: 8] = relu(acc[idx]);
      end
      chkWord("model", w, 8'(base + w), word);
    end
    if (cnt == 0) expDone = n + 2;
    else expDone = lastA + lastK + ((cnt % 4 == 0) ? 2 : 3);
    chk("done_count", doneCyc.size(), 1);
    chk("done_cycle", (doneCyc.size() > 0) ? doneCyc[0] : -1, expDone);
    if (cnt > 0) chk("last_wr_cycle", (wrCyc.size() > 0) ? wrCyc[wrCyc.size()-1] : -1, expDone - 1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(resReady), 32'd0);
  endtask

  task automatic chkOutputsZero(input string tag);
    chk({tag, "_we"}, 32'(memWe), 0);
    chk({tag, "_adr"}, 32'(memAdr), 0);
    chk({tag, "_dat"}, memData, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ready"}, 32'(resReady), 0);
  endtask

  initial begin
    int got, budget;
    rst = 1'b1; start = 1'b0; baseAdr = '0; outCount = '0; resValid = '0; resData = '0;
    repeat (3) @(negedge clk);
    chkOutputsZero("reset");
    rst = 1'b0;
    @(negedge clk);

    pat = '{8'h01, 8'h02, 8'h03, 8'h04};
    runJob(8'h10, 4, 1'b0, 1'b0);
    chkWord("t4", 0, 8'h10, 32'h04030201);

    pat = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    runJob(8'h10, 6, 1'b0, 1'b0);
    chkWord("t6w0", 0, 8'h10, 32'h14131211);
    chkWord("t6w1", 1, 8'h11, 32'h00001615);

    pat = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    runJob(8'h40, 4, 1'b1, 1'b0);
    chk("wave_together", firstK, 4);
`ifdef WRITER_RELU_EN
    chkWord("wave", 0, 8'h40, 32'h00000000);
`else
    chkWord("wave", 0, 8'h40, 32'hA3A2A1A0);
`endif

    pat.delete();
    runJob(8'hFF, 8, 1'b1, 1'b1);
    chk("wrap_a0", (wrAdr.size() > 0) ? 32'(wrAdr[0]) : 32'hx, 32'hFF);
    chk("wrap_a1", (wrAdr.size() > 1) ? 32'(wrAdr[1]) : 32'hx, 32'h00);

    pat = '{8'h80, 8'h7F, 8'hFF, 8'h01};
    runJob(8'h22, 4, 1'b0, 1'b1);
`ifdef WRITER_RELU_EN
    chkWord("relu", 0, 8'h22, 32'h01007F00);
`else
    chkWord("relu", 0, 8'h22, 32'h01FF7F80);
`endif

    runJob(8'h33, 0, 1'b0, 1'b0);

    // Reset with three of four bytes drained.
    clearLogs();
    start = 1'b1; baseAdr = 8'h20; outCount = 8'd4;
    @(negedge clk);
    start = 1'b0;
    got = 0; budget = 0;
    while (got < 3 && budget < 100) begin
      resValid[0] = 1'b1; resData[7:0] = 8'h31 + 8'(got);
      #1;
      if (resReady[0]) got++;
      @(negedge clk);
      budget++;
    end
    resValid = '0;
    chk("rst_accepts", got, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chkOutputsZero("midrst");
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_nowrite", wrAdr.size(), 0);

    pat = '{8'h55, 8'h66, 8'h77};
    runJob(8'h50, 3, 1'b0, 1'b0);
    chkWord("postrst", 0, 8'h50, {8'h00, relu(8'h77), relu(8'h66), relu(8'h55)});

    for (int r = 0; r < 6; r++) begin
      pat.delete();
      runJob(8'($urandom), $urandom_range(1, 20), 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
